// File: rtl/partial_product_accumulator.sv
// Shift-and-add unsigned multiplier: width x width -> 2*width product, one partial product per clock.
// Latency: valid_o rises width edges after the accepting edge; with PPA_ZERO_BYPASS_EN a zero operand finishes on the accepting edge.
// Backpressure: product_o is held in DONE until valid_o&ready_i; ready_o is low from accept until the cycle after that handshake.
module partial_product_accumulator #(
    parameter int width = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [width-1:0]     mcand_i,
    input  logic [width-1:0]     mplier_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*width-1:0]   product_o,
    output logic                 busy_o
);

    localparam int CW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [2*width-1:0]  p_q;
    logic [width-1:0]    mcand_q;
    logic [CW-1:0]       cnt_q;
    logic                accept;
    logic                last_iter;
    logic                zero_op;
    logic [width:0]      sum;

    assign accept    = start_i && (state == IDLE);
    assign last_iter = (cnt_q == CW'(width - 1));

`ifdef PPA_ZERO_BYPASS_EN
    assign zero_op = (mcand_i == '0) || (mplier_i == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Upper half plus multiplicand keeps the carry so the shift never drops it.
    assign sum = {1'b0, p_q[2*width-1:width]} + (p_q[0] ? {1'b0, mcand_q} : {(width+1){1'b0}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_op ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state)
            IDLE:    ready_o = 1'b1;
            ACCUM:   busy_o  = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_q     <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand_q <= mcand_i;
                        p_q     <= zero_op ? {(2*width){1'b0}} : {{width{1'b0}}, mplier_i};
                        cnt_q   <= '0;
                    end
                end
                ACCUM: begin
                    p_q   <= {sum, p_q[width-1:1]};
                    cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign product_o = p_q;

endmodule
